hazard_stall_ctrl: RTL and testbench

Decode-stage hazard and stall controller for the 5-stage ARM pipeline, the neighbour of the EXE-stage operand forwarding unit. It detects read-after-write hazards between the instruction in ID and the producers in EXE and MEM, using the same `en_forwarding` control as the forwarding unit. With forwarding on, only load-use hazards stall. It also holds the whole pipeline while the memory stage waits on a multi-cycle SRAM, and flushes on taken branches.

---
 rtl/hazard_stall_ctrl_if.sv | 41 ++++
 rtl/hazard_stall_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the decode-stage hazard/stall controller and the pipeline.
// The master side is the pipeline that drives the stage fields; the slave side is the controller.
interface hazard_stall_ctrl_if;
   logic        en_forwarding;
   logic [3:0]  ID_src1;
   logic [3:0]  ID_src2;
   logic        ID_two_src;
   logic        ID_valid;
   logic [3:0]  EXE_dst;
   logic        EXE_wb_en;
   logic        EXE_mem_r_en;
   logic [3:0]  MEM_dst;
   logic        MEM_wb_en;
   logic        MEM_access;
   logic        sram_ready;
   logic        branch_taken;
   logic        freeze_if;
   logic        bubble_ex;
   logic        freeze_all;
   logic        flush;
   logic        mem_timeout;
   logic [1:0]  state;
   logic [15:0] stall_cnt;
   logic [15:0] bubble_cnt;

   modport master (
      output en_forwarding, ID_src1, ID_src2, ID_two_src, ID_valid,
             EXE_dst, EXE_wb_en, EXE_mem_r_en, MEM_dst, MEM_wb_en,
             MEM_access, sram_ready, branch_taken,
      input  freeze_if, bubble_ex, freeze_all, flush, mem_timeout,
             state, stall_cnt, bubble_cnt
   );

   modport slave (
      input  en_forwarding, ID_src1, ID_src2, ID_two_src, ID_valid,
             EXE_dst, EXE_wb_en, EXE_mem_r_en, MEM_dst, MEM_wb_en,
             MEM_access, sram_ready, branch_taken,
      output freeze_if, bubble_ex, freeze_all, flush, mem_timeout,
             state, stall_cnt, bubble_cnt
   );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage RAW hazard, SRAM wait and branch flush controller with Mealy outputs.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined.
module hazard_stall_ctrl #(
   parameter int MEM_TIMEOUT = 64
) (
   input logic                clk,
   input logic                rst,
   hazard_stall_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      RUN        = 2'b00,
      LOAD_STALL = 2'b01,
      MEM_WAIT   = 2'b10
   } state_t;

   localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

   state_t     state_q, state_d;
   logic [7:0] tmo_cnt;
   logic [7:0] tmo_inc;
   logic       mem_timeout_q;

   logic exe_src1, exe_src2, mem_src1, mem_src2, exe_match;
   logic raw_hz, load_use, data_stall, mem_busy;
   logic freeze_if, bubble_ex, freeze_all, flush;

   assign exe_src1   = bus.EXE_wb_en & (bus.EXE_dst == bus.ID_src1);
   assign exe_src2   = bus.EXE_wb_en & bus.ID_two_src & (bus.EXE_dst == bus.ID_src2);
   assign mem_src1   = bus.MEM_wb_en & (bus.MEM_dst == bus.ID_src1);
   assign mem_src2   = bus.MEM_wb_en & bus.ID_two_src & (bus.MEM_dst == bus.ID_src2);
   assign exe_match  = exe_src1 | exe_src2;
   assign raw_hz     = bus.ID_valid & (exe_match | mem_src1 | mem_src2);
   assign load_use   = bus.ID_valid & bus.EXE_mem_r_en & exe_match;
   assign data_stall = bus.en_forwarding ? load_use : raw_hz;
   assign mem_busy   = bus.MEM_access & ~bus.sram_ready;

   // Priority everywhere is SRAM wait, then branch flush, then data hazard.
   always_comb begin
      state_d    = state_q;
      freeze_if  = 1'b0;
      bubble_ex  = 1'b0;
      freeze_all = 1'b0;
      flush      = 1'b0;
      case (state_q)
         RUN: begin
            if (mem_busy) begin
               freeze_all = 1'b1;
               state_d    = MEM_WAIT;
            end else if (bus.branch_taken) begin
               flush = 1'b1;
            end else if (data_stall) begin
               freeze_if = 1'b1;
               bubble_ex = 1'b1;
               state_d   = (bus.en_forwarding & load_use) ? LOAD_STALL : RUN;
            end
         end
         LOAD_STALL: begin
            // EXE now holds the bubble, so only the no-forwarding RAW check remains.
            state_d = RUN;
            if (mem_busy) begin
               freeze_all = 1'b1;
               state_d    = MEM_WAIT;
            end else if (bus.branch_taken) begin
               flush = 1'b1;
            end else if (~bus.en_forwarding & raw_hz) begin
               freeze_if = 1'b1;
               bubble_ex = 1'b1;
            end
         end
         MEM_WAIT: begin
            freeze_all = ~bus.sram_ready;
            state_d    = bus.sram_ready ? RUN : MEM_WAIT;
         end
         default: state_d = RUN;
      endcase
   end

   assign tmo_inc = (tmo_cnt == 8'hFF) ? 8'hFF : tmo_cnt + 8'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= RUN;
         tmo_cnt       <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q != MEM_WAIT && state_d == MEM_WAIT) begin
            tmo_cnt <= '0;
         end else if (state_q == MEM_WAIT) begin
            tmo_cnt <= tmo_inc;
            if (tmo_inc == TMO_LIMIT) mem_timeout_q <= 1'b1;
         end
      end
   end

   assign bus.freeze_if   = freeze_if;
   assign bus.bubble_ex   = bubble_ex;
   assign bus.freeze_all  = freeze_all;
   assign bus.flush       = flush;
   assign bus.mem_timeout = mem_timeout_q;
   assign bus.state       = state_q;

`ifdef HAZARD_STATS_EN
   logic [15:0] stall_q, bubble_q;

   // Saturating counters so long runs never wrap back to small values.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         if ((freeze_if | freeze_all) && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
         if (bubble_ex && bubble_q != 16'hFFFF) bubble_q <= bubble_q + 16'd1;
      end
   end

   assign bus.stall_cnt  = stall_q;
   assign bus.bubble_cnt = bubble_q;
`else
   assign bus.stall_cnt  = '0;
   assign bus.bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a behavioural model checks every cycle,
// and hand-computed literal expectations pin the key scenarios.
module tb_hazard_stall_ctrl;

   localparam int TMO = 64;
`ifdef HAZARD_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   hazard_stall_ctrl_if bus ();

   hazard_stall_ctrl #(.MEM_TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: 0 = running, 1 = the one cycle after a load bubble, 2 = waiting on SRAM.
   int m_state;
   int m_wait;
   bit m_tmo;
   int m_stall;
   int m_bubble;
   bit model_valid = 1'b0;

   function automatic bit reads_reg(input logic [3:0] r);
      return (bus.ID_src1 == r) || (bus.ID_two_src && (bus.ID_src2 == r));
   endfunction

   // Expected control outputs straight from the hazard rules and their priority order.
   task automatic model_outputs(output bit fi, output bit bx, output bit fa, output bit fl, output int nxt);
      bit raw, lu, busy, stall;
      raw  = bus.ID_valid && ((bus.EXE_wb_en && reads_reg(bus.EXE_dst)) ||
                              (bus.MEM_wb_en && reads_reg(bus.MEM_dst)));
      lu   = bus.ID_valid && bus.EXE_mem_r_en && bus.EXE_wb_en && reads_reg(bus.EXE_dst);
      busy = bus.MEM_access && !bus.sram_ready;
      fi = 0; bx = 0; fa = 0; fl = 0; nxt = 0;
      if (m_state == 2) begin
         fa  = !bus.sram_ready;
         nxt = bus.sram_ready ? 0 : 2;
      end else if (busy) begin
         fa  = 1;
         nxt = 2;
      end else if (bus.branch_taken) begin
         fl = 1;
      end else begin
         if (m_state == 1) stall = !bus.en_forwarding && raw;
         else              stall = bus.en_forwarding ? lu : raw;
         fi = stall;
         bx = stall;
         if (m_state == 0 && bus.en_forwarding && lu) nxt = 1;
      end
   endtask

   // Advance the model on each rising edge using the inputs the DUT sees.
   always @(posedge clk) begin
      bit fi, bx, fa, fl;
      int nxt, nw;
      if (rst) begin
         m_state     <= 0;
         m_wait      <= 0;
         m_tmo       <= 1'b0;
         m_stall     <= 0;
         m_bubble    <= 0;
         model_valid <= 1'b1;
      end else if (model_valid) begin
         model_outputs(fi, bx, fa, fl, nxt);
         if (m_state == 2) begin
            nw = (m_wait < 255) ? m_wait + 1 : 255;
            m_wait <= nw;
            if (nw == TMO) m_tmo <= 1'b1;
         end else if (nxt == 2) begin
            m_wait <= 0;
         end
         if ((fi || fa) && m_stall < 65535) m_stall <= m_stall + 1;
         if (bx && m_bubble < 65535) m_bubble <= m_bubble + 1;
         m_state <= nxt;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Compare every output against the model on each falling edge once reset has been seen.
   always @(negedge clk) begin
      bit fi, bx, fa, fl;
      int nxt;
      if (model_valid) begin
         model_outputs(fi, bx, fa, fl, nxt);
         checkOutput("m_freeze_if",   bus.freeze_if,   fi);
         checkOutput("m_bubble_ex",   bus.bubble_ex,   bx);
         checkOutput("m_freeze_all",  bus.freeze_all,  fa);
         checkOutput("m_flush",       bus.flush,       fl);
         checkOutput("m_state",       bus.state,       m_state);
         checkOutput("m_mem_timeout", bus.mem_timeout, m_tmo);
         checkOutput("m_stall_cnt",   bus.stall_cnt,   STATS ? m_stall : 0);
         checkOutput("m_bubble_cnt",  bus.bubble_cnt,  STATS ? m_bubble : 0);
      end
   end

   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.en_forwarding = 0; bus.ID_src1 = 0; bus.ID_src2 = 0; bus.ID_two_src = 0;
      bus.ID_valid = 0; bus.EXE_dst = 0; bus.EXE_wb_en = 0; bus.EXE_mem_r_en = 0;
      bus.MEM_dst = 0; bus.MEM_wb_en = 0; bus.MEM_access = 0; bus.sram_ready = 0;
      bus.branch_taken = 0;
   endtask

   task automatic set_load_use();
      bus.en_forwarding = 1; bus.EXE_mem_r_en = 1; bus.EXE_wb_en = 1;
      bus.EXE_dst = 4'd3; bus.ID_src1 = 4'd3; bus.ID_valid = 1;
   endtask

   // Directed scenarios with hand-computed expectations.
   initial begin
      n_vec = 0;
      n_err = 0;
      clear_inputs();
      rst = 1;
      applyStimulus(2);
      rst = 0;
      @(negedge clk);
      checkOutput("rst_state",      bus.state,       0);
      checkOutput("rst_freeze_if",  bus.freeze_if,   0);
      checkOutput("rst_freeze_all", bus.freeze_all,  0);
      checkOutput("rst_flush",      bus.flush,       0);
      checkOutput("rst_timeout",    bus.mem_timeout, 0);
      checkOutput("rst_stall_cnt",  bus.stall_cnt,   0);

      applyStimulus(1);
      set_load_use();
      @(negedge clk);
      checkOutput("lu_freeze_if", bus.freeze_if, 1);
      checkOutput("lu_bubble_ex", bus.bubble_ex, 1);
      checkOutput("lu_state0",    bus.state,     0);
      applyStimulus(1);
      @(negedge clk);
      checkOutput("lu_state1",     bus.state,     1);
      checkOutput("lu_released",   bus.freeze_if, 0);
      applyStimulus(1);
      clear_inputs();
      @(negedge clk);
      checkOutput("lu_state_back", bus.state, 0);

      applyStimulus(1);
      bus.en_forwarding = 0; bus.EXE_wb_en = 1; bus.EXE_dst = 4'd5;
      bus.ID_src2 = 4'd5; bus.ID_two_src = 1; bus.ID_valid = 1;
      @(negedge clk);
      checkOutput("raw_exe_stall", bus.freeze_if, 1);
      applyStimulus(1);
      bus.EXE_wb_en = 0; bus.MEM_dst = 4'd5; bus.MEM_wb_en = 1;
      @(negedge clk);
      checkOutput("raw_mem_stall", bus.freeze_if, 1);
      applyStimulus(1);
      bus.MEM_wb_en = 0;
      @(negedge clk);
      checkOutput("raw_retired", bus.freeze_if, 0);

      applyStimulus(1);
      bus.EXE_wb_en = 1; bus.EXE_dst = 4'd5; bus.ID_src2 = 4'd5; bus.ID_two_src = 0;
      @(negedge clk);
      checkOutput("src2_gated", bus.freeze_if, 0);

      applyStimulus(1);
      clear_inputs();
      bus.MEM_access = 1;
      for (int c = 1; c <= 70; c++) begin
         @(negedge clk);
         checkOutput("sram_freeze_all", bus.freeze_all, 1);
         if (c == 65) checkOutput("tmo_before", bus.mem_timeout, 0);
         if (c == 66) checkOutput("tmo_after",  bus.mem_timeout, 1);
         applyStimulus(1);
      end
      bus.sram_ready = 1;
      @(negedge clk);
      checkOutput("sram_ready_release", bus.freeze_all, 0);
      checkOutput("sram_ready_state",   bus.state,      2);
      applyStimulus(1);
      clear_inputs();
      @(negedge clk);
      checkOutput("sram_exit_state", bus.state,       0);
      checkOutput("tmo_sticky",      bus.mem_timeout, 1);

      applyStimulus(1);
      set_load_use();
      bus.branch_taken = 1;
      @(negedge clk);
      checkOutput("prio_br_flush",  bus.flush,     1);
      checkOutput("prio_br_bubble", bus.bubble_ex, 0);
      applyStimulus(1);
      bus.MEM_access = 1;
      @(negedge clk);
      checkOutput("prio_mem_freeze", bus.freeze_all, 1);
      checkOutput("prio_mem_flush",  bus.flush,      0);
      applyStimulus(1);
      bus.sram_ready = 1;
      @(negedge clk);
      checkOutput("wait_ignores_br", bus.flush, 0);
      applyStimulus(1);
      clear_inputs();

      bus.MEM_access = 1; bus.sram_ready = 1;
      @(negedge clk);
      checkOutput("same_cycle_ready", bus.freeze_all, 0);
      applyStimulus(1);
      clear_inputs();

      bus.MEM_access = 1;
      applyStimulus(3);
      @(negedge clk);
      checkOutput("mid_wait_state", bus.state, 2);
      rst = 1;
      clear_inputs();
      applyStimulus(1);
      rst = 0;
      @(negedge clk);
      checkOutput("rst_wait_state",  bus.state,       0);
      checkOutput("rst_wait_tmo",    bus.mem_timeout, 0);
      checkOutput("rst_wait_stall",  bus.stall_cnt,   0);
      checkOutput("rst_wait_bubble", bus.bubble_cnt,  0);

      for (int k = 0; k < 3; k++) begin
         applyStimulus(1);
         set_load_use();
         applyStimulus(1);
         clear_inputs();
      end
      @(negedge clk);
      checkOutput("stats_bubble_cnt", bus.bubble_cnt, STATS ? 3 : 0);
      checkOutput("stats_stall_cnt",  bus.stall_cnt,  STATS ? 3 : 0);
      applyStimulus(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
